// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and multiply-sequencer states for alu_pipe.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_INC   = 4'h1;
    localparam logic [3:0] OP_DEC   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_NOTB  = 4'h9;
    localparam logic [3:0] OP_SETC  = 4'hA;
    localparam logic [3:0] OP_CLRC  = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_ADC   = 4'hD;
    localparam logic [3:0] OP_SBB   = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Only compiled when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // High during the final step: product is complete from the next cycle on.
    assign done    = (cnt_q == CW'(1));
    assign product = acc_q;

endmodule
`endif

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and architectural Z/N/C/V flag register.
// Define ALU_PIPE_MUL_EN to compile in the multi-cycle multiplier for opcode 1100.
//
// state   | meaning
// IDLE    | accepting ops, single-cycle results load on accept
// MUL     | shift-add multiplier iterating, input stalled
// DONE    | product final, loads out/out_valid/flags this edge
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    input  logic             write_flag,
    input  logic [3:0]       input_flags
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       flags_q, flags_d;

    logic             out_free, fire, single_fire;
    logic             mul_load;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_ext, shr_ext;
    logic             c_new, v_new, zn_upd, v_upd;
    logic [3:0]       alu_flags;

    assign out_free = !out_valid_q || out_ready;
    assign fire     = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    alu_state_e         state_q, state_d;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (input_1),
        .b       (input_2),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire && alu_op == OP_MUL) begin
                    state_d   = ST_MUL;
                    mul_start = 1'b1;
                end
            end
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign in_ready    = (state_q == ST_IDLE) && out_free;
    assign single_fire = fire && (alu_op != OP_MUL);
    assign mul_load    = (state_q == ST_DONE);
    assign mul_res     = mul_prod[WIDTH-1:0];
    assign mul_flags   = {(mul_prod[2*WIDTH-1:WIDTH] != '0),
                          (mul_prod[2*WIDTH-1:WIDTH] != '0),
                          mul_prod[MSB],
                          (mul_prod[WIDTH-1:0] == '0)};
`else
    assign in_ready    = out_free;
    assign single_fire = fire;
    assign mul_load    = 1'b0;
    assign mul_res     = '0;
    assign mul_flags   = 4'b0000;
`endif

    // Shift helpers: the bit pushed out lands in shl_ext[WIDTH] / shr_ext[0].
    assign shl_ext = {1'b0, input_1} << input_2;
    assign shr_ext = {input_1, 1'b0} >> input_2;

    always_comb begin
        res    = input_1;
        sum    = '0;
        c_new  = flags_q[FLG_C];
        v_new  = 1'b0;
        zn_upd = 1'b1;
        v_upd  = 1'b1;
        case (alu_op)
            OP_PASSA: res = input_1;
            OP_INC: begin
                sum   = {1'b0, input_1} + {{WIDTH{1'b0}}, 1'b1};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = !input_1[MSB] && res[MSB];
            end
            OP_DEC: begin
                sum   = {1'b0, input_1} - {{WIDTH{1'b0}}, 1'b1};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = input_1[MSB] && !res[MSB];
            end
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, input_1} + {1'b0, input_2}
                      + {{WIDTH{1'b0}}, (alu_op == OP_ADC) && flags_q[FLG_C]};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = (input_1[MSB] == input_2[MSB]) && (res[MSB] != input_1[MSB]);
            end
            OP_SUB, OP_SBB: begin
                sum   = {1'b0, input_1} - {1'b0, input_2}
                      - {{WIDTH{1'b0}}, (alu_op == OP_SBB) && flags_q[FLG_C]};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = (input_1[MSB] != input_2[MSB]) && (res[MSB] != input_1[MSB]);
            end
            OP_AND:  res = input_1 & input_2;
            OP_OR:   res = input_1 | input_2;
            OP_SHL, OP_SHR: begin
                if (input_2 == '0) begin
                    res = input_1;
                end else if (input_2 > W_AMT) begin
                    res   = '0;
                    c_new = 1'b0;
                end else if (alu_op == OP_SHL) begin
                    res   = shl_ext[WIDTH-1:0];
                    c_new = shl_ext[WIDTH];
                end else begin
                    res   = shr_ext[WIDTH:1];
                    c_new = shr_ext[0];
                end
            end
            OP_NOTB: res = ~input_2;
            OP_SETC, OP_CLRC: begin
                res    = input_1;
                c_new  = (alu_op == OP_SETC);
                zn_upd = 1'b0;
                v_upd  = 1'b0;
            end
            OP_MUL:   res = input_1;
            OP_PASSB: res = input_2;
            default:  res = input_1;
        endcase

        alu_flags = flags_q;
        if (zn_upd) begin
            alu_flags[FLG_Z] = (res == '0);
            alu_flags[FLG_N] = res[MSB];
        end
        alu_flags[FLG_C] = c_new;
        if (v_upd) alu_flags[FLG_V] = v_new;
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        if (single_fire) begin
            out_d       = res;
            out_valid_d = 1'b1;
        end else if (mul_load) begin
            out_d       = mul_res;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A direct flag load wins; the colliding op still delivers its result.
        if (write_flag)       flags_d = input_flags;
        else if (single_fire) flags_d = alu_flags;
        else if (mul_load)    flags_d = mul_flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed cases plus randomized traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [3:0]    alu_op;
    logic [W-1:0]  input_1, input_2;
    logic          out_valid, out_ready;
    logic [W-1:0]  out;
    logic [3:0]    flags;
    logic          write_flag;
    logic [3:0]    input_flags;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .input_1     (input_1),
        .input_2     (input_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .flags       (flags),
        .write_flag  (write_flag),
        .input_flags (input_flags)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_out;
    logic         m_valid;
    logic [3:0]   m_flags;
    int           m_mul_left;
    logic [31:0]  m_prod;

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic void model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [3:0] fin,
                                      output logic [W-1:0] r, output logic [3:0] fout);
        longint ua, ub, cin, full, sres;
        bit arith, zn;
        ua = a; ub = b; cin = fin[2];
        fout = fin; zn = 1; arith = 0; full = ua; sres = 0;
        case (op)
            4'h1: begin full = ua + 1; fout[2] = full > 65535; sres = sx(a) + 1; arith = 1; end
            4'h2: begin full = ua - 1; fout[2] = ua < 1; sres = sx(a) - 1; arith = 1; end
            4'h3: begin full = ua + ub; fout[2] = full > 65535; sres = sx(a) + sx(b); arith = 1; end
            4'h4: begin full = ua - ub; fout[2] = ua < ub; sres = sx(a) - sx(b); arith = 1; end
            4'h5: full = ua & ub;
            4'h6: full = ua | ub;
            4'h7: begin
                if (ub == 0) full = ua;
                else if (ub <= W) begin full = ua << ub; fout[2] = ((full >> W) & 1) != 0; end
                else begin full = 0; fout[2] = 0; end
            end
            4'h8: begin
                if (ub == 0) full = ua;
                else if (ub <= W) begin full = ua >> ub; fout[2] = ((ua >> (ub - 1)) & 1) != 0; end
                else begin full = 0; fout[2] = 0; end
            end
            4'h9: full = 65535 - ub;
            4'hA: begin full = ua; fout[2] = 1; zn = 0; end
            4'hB: begin full = ua; fout[2] = 0; zn = 0; end
            4'hD: begin full = ua + ub + cin; fout[2] = full > 65535; sres = sx(a) + sx(b) + cin; arith = 1; end
            4'hE: begin full = ua - ub - cin; fout[2] = ua < ub + cin; sres = sx(a) - sx(b) - cin; arith = 1; end
            4'hF: full = ub;
            default: full = ua;
        endcase
        r = full[W-1:0];
        if (zn) begin
            fout[0] = (r == 0);
            fout[1] = r[W-1];
        end
        if (op != 4'hA && op != 4'hB) fout[3] = arith ? (sres > 32767 || sres < -32768) : 1'b0;
    endfunction

    function automatic logic m_ready();
        return (m_mul_left == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] r;
        logic [3:0]   nf;
        bit           load, upd, fire;
        if (rst) begin
            m_out = '0; m_valid = 1'b0; m_flags = 4'b0; m_mul_left = 0; m_prod = '0;
        end else begin
            load = 0; upd = 0; r = m_out; nf = m_flags;
            fire = in_valid && m_ready();
            if (m_mul_left > 0) begin
                m_mul_left--;
                if (m_mul_left == 0) begin
                    load = 1; upd = 1;
                    r  = m_prod[15:0];
                    nf = {m_prod[31:16] != 0, m_prod[31:16] != 0, m_prod[15], m_prod[15:0] == 0};
                end
            end else if (fire) begin
                if (MUL_EN && alu_op == 4'hC) begin
                    m_mul_left = W + 1;
                    m_prod     = 32'(input_1) * 32'(input_2);
                end else begin
                    model_alu(alu_op, input_1, input_2, m_flags, r, nf);
                    load = 1; upd = 1;
                end
            end
            if (load) begin m_out = r; m_valid = 1'b1; end
            else if (out_ready) m_valid = 1'b0;
            if (write_flag) m_flags = input_flags;
            else if (upd)   m_flags = nf;
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("in_ready", in_ready, m_ready());
            check("out_valid", out_valid, m_valid);
            if (m_valid) check("out", out, m_out);
            check("flags", flags, m_flags);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic wf, input logic [3:0] fl);
        alu_op = op; input_1 = a; input_2 = b; in_valid = 1'b1;
        write_flag = wf; input_flags = fl;
        step();
        in_valid = 1'b0; write_flag = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] sp [5];
        sp[0] = 16'h0000; sp[1] = 16'h0001; sp[2] = 16'h7FFF; sp[3] = 16'h8000; sp[4] = 16'hFFFF;
        if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
        return W'($urandom);
    endfunction

    initial begin
        logic [W-1:0] pr;
        logic [3:0]   pf;
        int lat;
        bit ir_seen, v_seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = 4'h0;
        input_1 = '0; input_2 = '0; write_flag = 1'b0; input_flags = 4'h0;

        model_alu(4'hD, 16'hFFFF, 16'h0000, 4'b0100, pr, pf);
        check("pin_adc_out", pr, 16'h0000);
        check("pin_adc_flags", pf, 4'b0101);
        model_alu(4'hE, 16'h8000, 16'h0000, 4'b0100, pr, pf);
        check("pin_sbb_out", pr, 16'h7FFF);
        check("pin_sbb_flags", pf, 4'b1000);
        model_alu(4'h8, 16'h8000, 16'd16, 4'b0000, pr, pf);
        check("pin_shr16_flags", pf, 4'b0101);

        repeat (2) step();
        rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_out", out, 16'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_flags", flags, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);

        do_op(4'h3, 16'hFFFF, 16'h0001, 1'b0, 4'h0);
        check("pre_rst_flags", flags, 4'b0101);
        rst = 1'b1; #1;
        check("midrst_out", out, 16'h0);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_flags", flags, 4'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        step(); rst = 1'b0;

        write_flag = 1'b1; input_flags = 4'b0100;
        step(); write_flag = 1'b0;
        check("wflag_load", flags, 4'b0100);

        do_op(4'h3, 16'h7FFF, 16'h0001, 1'b0, 4'h0);
        check("add_ovf_out", out, 16'h8000);
        check("add_ovf_flags", flags, 4'b1010);
        do_op(4'h4, 16'h0000, 16'h0001, 1'b0, 4'h0);
        check("sub_borrow_out", out, 16'hFFFF);
        check("sub_borrow_flags", flags, 4'b0110);
        do_op(4'h7, 16'h8001, 16'd1, 1'b0, 4'h0);
        check("shl1_out", out, 16'h0002);
        check("shl1_flags", flags, 4'b0100);
        do_op(4'h8, 16'h0003, 16'd2, 1'b0, 4'h0);
        check("shr2_out", out, 16'h0000);
        check("shr2_flags", flags, 4'b0101);
        do_op(4'h7, 16'h1234, 16'd20, 1'b0, 4'h0);
        check("shl20_out", out, 16'h0000);
        check("shl20_flags", flags, 4'b0001);
        do_op(4'hA, 16'h1234, 16'h0, 1'b1, 4'b1000);
        check("collide_out", out, 16'h1234);
        check("collide_flags", flags, 4'b1000);
`ifndef ALU_PIPE_MUL_EN
        do_op(4'hC, 16'h5A5A, 16'h0003, 1'b0, 4'h0);
        check("mul_off_out", out, 16'h5A5A);
        check("mul_off_flags", flags, 4'b0000);
`endif

        // backpressure: three ops, consumer stalls two cycles
        step();
        out_ready = 1'b0;
        alu_op = 4'h3; input_1 = 16'd1; input_2 = 16'd1; in_valid = 1'b1;
        step();
        check("bp_first", out, 16'd2);
        check("bp_in_ready", in_ready, 1'b0);
        input_1 = 16'd2; input_2 = 16'd2;
        step();
        check("bp_hold_out", out, 16'd2);
        check("bp_hold_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        check("bp_second", out, 16'd4);
        input_1 = 16'd3; input_2 = 16'd3;
        step();
        in_valid = 1'b0;
        check("bp_third", out, 16'd6);

`ifdef ALU_PIPE_MUL_EN
        alu_op = 4'hC; input_1 = 16'h0100; input_2 = 16'h0100; in_valid = 1'b1;
        step();
        alu_op = 4'h3; input_1 = 16'd1; input_2 = 16'd2;
        out_ready = 1'b0;
        lat = 0; ir_seen = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_seen = 1;
            step();
            lat++;
        end
        lat++;
        check("mul_latency", lat, 17);
        check("mul_out", out, 16'h0000);
        check("mul_flags", flags, 4'b1101);
        check("mul_no_ready", ir_seen, 1'b0);
        step();
        check("mul_hold", out, 16'h0000);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_mul_add", out, 16'd3);

        alu_op = 4'hC; input_1 = 16'h00FF; input_2 = 16'h0101; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1; #1;
        check("mul_abort_flags", flags, 4'h0);
        step(); rst = 1'b0;
        v_seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (out_valid) v_seen = 1;
            step();
        end
        check("mul_abort_noresult", v_seen, 1'b0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(399) == 0);
            in_valid    = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(3) != 0);
            alu_op      = 4'($urandom);
            input_1     = pick_operand();
            input_2     = (alu_op == 4'h7 || alu_op == 4'h8) ? W'($urandom_range(19)) : pick_operand();
            write_flag  = ($urandom_range(9) == 0);
            input_flags = 4'($urandom);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; write_flag = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle 16-bit ALU. It keeps the 4-bit opcode map and the Z/N/C/V flag register, and adds several things:

- width parametrisation;
- valid/ready flow control on input and output;
- add/sub-with-carry;
- shift carry-out for both directions;
- an optional iterative multi-cycle multiplier.

It sits between the decode/operand-fetch stage and writeback, and owns the architectural flag register.

## Interface
- WIDTH, 16, operand/result width (≥4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  4  opcode
- input_1  in  WIDTH  operand A
- input_2  in  WIDTH  operand B / shift amount (unsigned)
- out_valid  out  1  result held in `out`
- out_ready  in  1  consumer takes result
- out  out  WIDTH  registered result
- flags  out  4  flag register: [0]=Z, [1]=N, [2]=C, [3]=V
- write_flag  in  1  load flag register from input_flags
- input_flags  in  4  flag value for direct load

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Opcodes:
  - 0000 pass A
  - 0001 A+1
  - 0010 A-1
  - 0011 A+B
  - 0100 A-B
  - 0101 A&B
  - 0110 A|B
  - 0111 A<<B
  - 1000 A>>B (logical)
  - 1001 ~B
  - 1010 set C
  - 1011 clear C
  - 1100 A*B (multiplier)
  - 1101 A+B+C
  - 1110 A-B-C
  - 1111 pass B
- Arithmetic is computed at WIDTH+1 bits.
- C rules:
  - For add, inc and adc, C = carry out.
  - For sub, dec and sbb, C = borrow: 1 when A < B(+Cin) unsigned.
- V is set to signed overflow for 0001–0100, 1101 and 1110. V is cleared for every other op, except 1010/1011, which leave it unchanged.
- Shifts (s = unsigned input_2):
  - s==0: result A, C unchanged.
  - 1≤s≤WIDTH: shl C=A[WIDTH-s], shr C=A[s-1].
  - s>WIDTH: result 0, C=0.
- Logic, pass and not ops leave C unchanged.
- 1010/1011: out=A; only C is written; Z, N and V are unchanged.
- Z=(result==0) and N=result[WIDTH-1] are updated by every op except 1010/1011.
- Multiply:
  - out = low WIDTH bits of the unsigned product.
  - C = V = (high WIDTH bits ≠ 0).
  - Z and N are taken from the low half.
- Flag register priority in the same cycle: write_flag beats ALU update.
- If write_flag and an op's flag update coincide, the op's result is still delivered, but its flag update is discarded.

## Timing
- Reset values: out=0, out_valid=0, flags=4'b0000, state=IDLE. in_ready=1 after reset deasserts.
- Single-cycle ops:
  - Accept at edge n → out and out_valid valid after edge n.
  - Flags update at the same edge.
  - Back-to-back throughput is 1/cycle while out_ready=1.
- Output hold: out and out_valid stay stable while out_valid && !out_ready. in_ready is 0 during this hold.
- Multiply FSM:
  - IDLE → MUL on accept of 1100. MUL runs WIDTH cycles of shift-add using a counter.
  - MUL → DONE → IDLE. In DONE, out, out_valid and flags load.
  - Latency: WIDTH+1 edges after accept.
  - in_ready=0 throughout MUL and DONE.
- write_flag is sampled on the rising edge; the new flags are visible the next cycle.
- Reset mid-multiply: the operation is aborted, no result is produced, and flags return to 0.
- Unused opcode 1100 without the multiplier: treated as pass A, with V=0.

## Configuration
- ALU_PIPE_MUL_EN:
  - Defined: the multiplier sub-module and the MUL/DONE states are compiled in.
  - Undefined: the FSM is absent, 1100 behaves as pass A, and in_ready depends only on the output hold.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_PASSA … OP_PASSB);
  - flag index constants (FLG_Z, FLG_N, FLG_C, FLG_V);
  - the FSM state enum (ST_IDLE, ST_MUL, ST_DONE).
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/done, WIDTH parameter, 2·WIDTH product. It is instantiated only under ALU_PIPE_MUL_EN.

## Test plan
All cases use WIDTH=16.
- **Reset and load:** rst pulse mid-stream → out=0, out_valid=0, flags=0, in_ready=1. Then write_flag=1 with input_flags=4'b0100 → flags=4'b0100 next cycle.
- **Add overflow:** 0011 with A=16'h7FFF, B=16'h0001 → out=16'h8000, flags Z0 N1 C0 V1. Then 0100 with A=0, B=1 → out=16'hFFFF, C=1 (borrow), V=0.
- **Shifts:**
  - 0111 with A=16'h8001, B=1 → out=16'h0002, C=1.
  - 1000 with A=16'h0003, B=2 → out=0, Z=1, C=1.
  - 0111 with B=20 → out=0, C=0.
- **Backpressure:** in_valid held for 3 ops with out_ready=0 for 2 cycles → first result held stable, in_ready=0, and no op lost; ordering is preserved once out_ready=1.
- **Multiply** (ALU_PIPE_MUL_EN): 1100 with A=16'h0100, B=16'h0100 → out_valid 17 cycles after accept, out=0, Z=1, C=1, V=1. A second accept is impossible until out_valid clears. rst asserted in cycle 5 → no result.
- **Flag collision:** write_flag=1 with input_flags=4'b1000 in the same cycle as 1010 is accepted → flags=4'b1000 and out=A delivered.
